// File: rtl/pipe_word_deserializer_pkg.sv
// Shared definitions for the request-pipe word serializer/deserializer pair:
// header field layout, frame FSM states and request tag constants.
package pipe_word_deserializer_pkg;

  localparam int unsigned MSG_WORDS_DEFAULT = 6;
  localparam int unsigned WORD_W            = 32;

  localparam int unsigned TAG_LSB = 0;
  localparam int unsigned TAG_W   = 16;
  localparam int unsigned LEN_LSB = 16;
  localparam int unsigned LEN_W   = 16;

  typedef enum logic [1:0] {
    HDR     = 2'd0,
    COLLECT = 2'd1,
    DISCARD = 2'd2
  } pipe_state_e;

  localparam logic [TAG_W-1:0] TAG_SAY  = 16'd1;
  localparam logic [TAG_W-1:0] TAG_SAY2 = 16'd2;

  // A header is usable only if it carries a tag and a payload that fits the message.
  function automatic logic hdr_valid(input logic [WORD_W-1:0] hdr,
                                     input int unsigned       msg_words);
    logic [TAG_W-1:0] tag;
    logic [LEN_W-1:0] len;
    tag = hdr[TAG_LSB +: TAG_W];
    len = hdr[LEN_LSB +: LEN_W];
    return (tag != '0) && (len != '0) && (len <= LEN_W'(msg_words - 1));
  endfunction

endpackage

// File: rtl/pipe_word_deserializer_sat_counter.sv
// Saturating event counter: counts up on inc_i and sticks at all-ones.
module sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             inc_i,
  output logic [CNT_W-1:0] count_o
);

  logic [CNT_W-1:0] count_q;

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      count_q <= '0;
    end else if (inc_i && (count_q != '1)) begin
      count_q <= count_q + CNT_W'(1);
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/pipe_word_deserializer.sv
// Receive end of the request pipe: reassembles header+payload word frames into
// one tagged MSG_WORDS*32-bit message, dropping and counting malformed frames.
module pipe_word_deserializer
  import pipe_word_deserializer_pkg::*;
#(
  parameter int unsigned MSG_WORDS = MSG_WORDS_DEFAULT,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                        CLK,
  input  logic                        nRST,
  input  logic                        word_enq__ENA,
  input  logic [WORD_W-1:0]           word_enq_v,
  output logic                        word_enq__RDY,
  output logic                        pipe_enq__ENA,
  output logic [MSG_WORDS*WORD_W-1:0] pipe_enq_v,
  input  logic                        pipe_enq__RDY,
  output logic [CNT_W-1:0]            frames_ok,
  output logic [CNT_W-1:0]            frames_err
);

  localparam int unsigned MSG_W = MSG_WORDS * WORD_W;
  localparam int unsigned IDX_W = $clog2(MSG_WORDS);

  localparam logic [1:0] ST_HDR     = HDR;
  localparam logic [1:0] ST_COLLECT = COLLECT;
  localparam logic [1:0] ST_DISCARD = DISCARD;

  logic [1:0]       state_q,    state_d;
  logic [LEN_W-1:0] remain_q,   remain_d;
  logic [IDX_W-1:0] idx_q,      idx_d;
  logic [MSG_W-1:0] asm_buf_q,  asm_buf_d;
  logic [MSG_W-1:0] out_buf_q,  out_buf_d;
  logic             out_full_q, out_full_d;
  logic [CNT_W-1:0] frames_ok_q;

  logic             deliver;
  logic             word_rdy;
  logic             word_acc;
  logic             err_inc;
  logic [TAG_W-1:0] hdr_tag;
  logic [LEN_W-1:0] hdr_len;

  assign hdr_tag = word_enq_v[TAG_LSB +: TAG_W];
  assign hdr_len = word_enq_v[LEN_LSB +: LEN_W];

  assign deliver  = out_full_q & pipe_enq__RDY;
  // Only the closing payload word needs the holding buffer, so only it can stall.
  assign word_rdy = !((state_q == ST_COLLECT) && (remain_q == LEN_W'(1)) &&
                      out_full_q && !deliver);
  assign word_acc = word_enq__ENA & word_rdy;

  always_comb begin
    state_d    = state_q;
    remain_d   = remain_q;
    idx_d      = idx_q;
    asm_buf_d  = asm_buf_q;
    out_buf_d  = out_buf_q;
    out_full_d = out_full_q;
    err_inc    = 1'b0;

    if (deliver) begin
      out_full_d = 1'b0;
    end

    if (word_acc) begin
      case (state_q)
        ST_HDR: begin
          if (hdr_valid(word_enq_v, MSG_WORDS)) begin
            state_d               = ST_COLLECT;
            asm_buf_d             = '0;
            asm_buf_d[TAG_W-1:0]  = hdr_tag;
            remain_d              = hdr_len;
            idx_d                 = IDX_W'(1);
          end else begin
            err_inc  = 1'b1;
            remain_d = hdr_len;
            if (hdr_len != '0) begin
              state_d = ST_DISCARD;
            end
          end
        end
        ST_COLLECT: begin
          for (int unsigned i = 1; i < MSG_WORDS; i++) begin
            if (idx_q == IDX_W'(i)) begin
              asm_buf_d[i*WORD_W +: WORD_W] = word_enq_v;
            end
          end
          idx_d    = idx_q + IDX_W'(1);
          remain_d = remain_q - LEN_W'(1);
          // Hand the merged buffer straight to the holding register; a same-cycle
          // delivery of the previous message keeps out_full set.
          if (remain_q == LEN_W'(1)) begin
            out_buf_d  = asm_buf_d;
            out_full_d = 1'b1;
            state_d    = ST_HDR;
          end
        end
        ST_DISCARD: begin
          remain_d = remain_q - LEN_W'(1);
          if (remain_q == LEN_W'(1)) begin
            state_d = ST_HDR;
          end
        end
        default: begin
          state_d = ST_HDR;
        end
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q     <= ST_HDR;
      remain_q    <= '0;
      idx_q       <= '0;
      asm_buf_q   <= '0;
      out_buf_q   <= '0;
      out_full_q  <= 1'b0;
      frames_ok_q <= '0;
    end else begin
      state_q    <= state_d;
      remain_q   <= remain_d;
      idx_q      <= idx_d;
      asm_buf_q  <= asm_buf_d;
      out_buf_q  <= out_buf_d;
      out_full_q <= out_full_d;
      if (deliver) begin
        frames_ok_q <= frames_ok_q + CNT_W'(1);
      end
    end
  end

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_err_cnt (
    .CLK     (CLK),
    .nRST    (nRST),
    .inc_i   (err_inc),
    .count_o (frames_err)
  );

  assign word_enq__RDY = word_rdy;
  assign pipe_enq__ENA = deliver;
  assign pipe_enq_v    = out_buf_q;
  assign frames_ok     = frames_ok_q;

endmodule

// File: tb/tb_pipe_word_deserializer.sv
// Frame-level scoreboard bench for pipe_word_deserializer: expected messages and
// counters are built from the frames the bench sends.
module tb_pipe_word_deserializer;

  localparam int unsigned MW = 6;
  localparam int unsigned VW = MW * 32;

  logic          CLK = 1'b0;
  logic          nRST = 1'b0;
  logic          word_ena = 1'b0;
  logic [31:0]   word_v = '0;
  logic          word_rdy;
  logic          pipe_ena;
  logic [VW-1:0] pipe_v;
  logic          pipe_rdy = 1'b1;
  logic [15:0]   frames_ok;
  logic [15:0]   frames_err;

  int unsigned   n_cmp = 0;
  int unsigned   n_bad = 0;
  int            rdy_mode = 1;   // 0 = hold low, 1 = hold high, 2 = random
  logic [VW-1:0] exp_q[$];
  int unsigned   exp_ok = 0;
  logic [15:0]   exp_err = '0;

  pipe_word_deserializer #(
    .MSG_WORDS (MW),
    .CNT_W     (16)
  ) dut (
    .CLK           (CLK),
    .nRST          (nRST),
    .word_enq__ENA (word_ena),
    .word_enq_v    (word_v),
    .word_enq__RDY (word_rdy),
    .pipe_enq__ENA (pipe_ena),
    .pipe_enq_v    (pipe_v),
    .pipe_enq__RDY (pipe_rdy),
    .frames_ok     (frames_ok),
    .frames_err    (frames_err)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    #1;
    pipe_rdy = (rdy_mode == 2) ? 1'($urandom_range(0, 1)) : (rdy_mode == 1);
  end

  task automatic check_val(input string tag, input logic [VW-1:0] got, input logic [VW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge CLK) begin
    if (nRST && pipe_ena) begin
      if (exp_q.size() == 0) check_val("spurious_ena", VW'(pipe_ena), '0);
      else check_val("msg", pipe_v, exp_q.pop_front());
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // All tasks are entered and left 2 time units after a rising edge.
  task automatic do_reset(input int unsigned cycles);
    nRST = 1'b0;
    word_ena = 1'b0;
    repeat (cycles) @(posedge CLK);
    #2;
    nRST = 1'b1;
    exp_q.delete();
    exp_ok = 0;
    exp_err = '0;
  endtask

  task automatic send_word(input logic [31:0] w);
    int unsigned waited = 0;
    word_v = w;
    while (!word_rdy) begin
      word_ena = 1'b0;
      @(posedge CLK);
      #2;
      waited++;
      if (waited > 2000) begin
        check_val("rdy_timeout", VW'(word_rdy), VW'(1));
        return;
      end
    end
    word_ena = 1'b1;
    @(posedge CLK);
    #2;
    word_ena = 1'b0;
  endtask

  task automatic send_frame(input logic [15:0] tag, input logic [15:0] len,
                            input int unsigned n, input bit fixed, input bit probe);
    logic [VW-1:0] msg;
    logic [31:0]   w;
    msg = '0;
    msg[15:0] = tag;
    send_word({len, tag});
    if (tag == 0 || len == 0 || len > MW - 1) begin
      if (exp_err != 16'hFFFF) exp_err++;
    end
    for (int i = 0; i < int'(n); i++) begin
      w = fixed ? 32'h11 * (i + 1) : $urandom;
      if (probe && i == int'(n) - 1) begin
        check_val("stall_rdy", VW'(word_rdy), '0);
        repeat (3) @(posedge CLK);
        #2;
        check_val("stall_rdy_held", VW'(word_rdy), '0);
        check_val("stall_no_ena", VW'(pipe_ena), '0);
        rdy_mode = 1;
        @(posedge CLK);
        #2;
      end
      send_word(w);
      if (i + 1 < int'(MW)) msg[(i+1)*32 +: 32] = w;
    end
    if (tag != 0 && len >= 1 && len <= MW - 1) begin
      exp_q.push_back(msg);
      exp_ok++;
    end
  endtask

  task automatic drain();
    int unsigned n = 0;
    do begin
      @(posedge CLK);
      n++;
    end while (exp_q.size() != 0 && n < 4000);
    #2;
    check_val("drain_empty", VW'(exp_q.size()), '0);
  endtask

  task automatic check_counters(input string tag);
    check_val({tag, "_ok"}, VW'(frames_ok), VW'(16'(exp_ok)));
    check_val({tag, "_err"}, VW'(frames_err), VW'(exp_err));
  endtask

  initial begin
    @(posedge CLK);
    #2;
    do_reset(2);
    check_val("rst_word_rdy", VW'(word_rdy), VW'(1));
    check_val("rst_pipe_ena", VW'(pipe_ena), '0);
    check_val("rst_pipe_v", pipe_v, '0);
    check_counters("rst");

    // Basic frame and one-cycle latency.
    send_frame(16'd1, 16'd2, 2, 1'b1, 1'b0);
    @(negedge CLK);
    check_val("t1_latency_ena", VW'(pipe_ena), VW'(1));
    @(posedge CLK);
    #2;
    check_counters("t1");

    // Backpressure: second frame's last word stalls until downstream is ready.
    do_reset(1);
    rdy_mode = 0;
    send_frame(16'd1, 16'd2, 2, 1'b0, 1'b0);
    send_frame(16'd2, 16'd2, 2, 1'b0, 1'b1);
    drain();
    check_counters("t2");

    // Zero tag header with payload, then a good frame.
    do_reset(1);
    send_frame(16'd0, 16'd3, 3, 1'b0, 1'b0);
    send_frame(16'd2, 16'd1, 1, 1'b0, 1'b0);
    drain();
    check_counters("t3");

    // Oversized frame discarded; zero-length header stays in header state.
    do_reset(1);
    send_frame(16'd1, 16'd9, 9, 1'b0, 1'b0);
    send_frame(16'd3, 16'd4, 4, 1'b0, 1'b0);
    send_frame(16'd1, 16'd0, 0, 1'b0, 1'b0);
    send_frame(16'd2, 16'd5, 5, 1'b0, 1'b0);
    drain();
    check_counters("t4");

    // Reset with a held message and a partial frame in flight.
    do_reset(1);
    rdy_mode = 0;
    send_frame(16'd4, 16'd1, 1, 1'b0, 1'b0);
    send_word({16'd2, 16'd1});
    send_word(32'hDEAD_BEEF);
    rdy_mode = 1;
    do_reset(1);
    check_val("t5_no_ena", VW'(pipe_ena), '0);
    check_counters("t5_rst");
    send_frame(16'd1, 16'd2, 2, 1'b0, 1'b0);
    drain();
    check_counters("t5");

    // Error counter saturation.
    do_reset(1);
    force dut.u_err_cnt.count_q = 16'hFFFF;
    @(posedge CLK);
    #2;
    release dut.u_err_cnt.count_q;
    exp_err = 16'hFFFF;
    send_frame(16'd0, 16'd0, 0, 1'b0, 1'b0);
    check_val("t6_sat", VW'(frames_err), VW'(exp_err));
    send_frame(16'd5, 16'd7, 7, 1'b0, 1'b0);
    check_val("t6_sat2", VW'(frames_err), VW'(16'hFFFF));

    // Random stream with random downstream readiness.
    do_reset(1);
    rdy_mode = 2;
    for (int f = 0; f < 1000; f++) begin
      logic [15:0] len;
      len = 16'($urandom_range(1, MW - 1));
      send_frame(16'($urandom_range(1, 65535)), len, len, 1'b0, 1'b0);
    end
    drain();
    check_counters("t7");
    check_val("t7_total", VW'(frames_ok), VW'(16'd1000));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
